// File: rtl/rp_asg_ramp_if.sv
// Sample/control bundle between an ASG channel and its soft-start ramp stage.
// Member names are seen from the ramp stage: *_i enter the ramp, *_o leave it.
interface rp_asg_ramp_if #(
    parameter int unsigned DW = 14,
    parameter int unsigned GW = 16
);
    logic [DW-1:0] dat_i;
    logic          en_i;
    logic [GW-1:0] set_step_i;
    logic [15:0]   set_rate_i;
    logic [DW-1:0] dat_o;
    logic [GW-1:0] gain_o;
    logic [1:0]    state_o;
    logic          done_o;

    // Ramp stage side.
    modport slave (
        input  dat_i,
        input  en_i,
        input  set_step_i,
        input  set_rate_i,
        output dat_o,
        output gain_o,
        output state_o,
        output done_o
    );

    // Upstream side: ASG channel plus configuration.
    modport master (
        output dat_i,
        output en_i,
        output set_step_i,
        output set_rate_i,
        input  dat_o,
        input  gain_o,
        input  state_o,
        input  done_o
    );
endinterface

// File: rtl/rp_asg_ramp.sv
// Soft-start/soft-stop gain stage for one ASG channel. Ramps a Q1.15 gain
// between 0 and 1.0 on enable/disable and applies it to the sample stream
// through a two-register multiply pipeline.
module rp_asg_ramp #(
    parameter int unsigned DW = 14,
    parameter int unsigned GW = 16
) (
    input  logic dac_clk_i,
    input  logic dac_rst_i,
    rp_asg_ramp_if.slave bus_if
);

    localparam logic [GW-1:0] GainMax = GW'(1) << (GW - 1);
    localparam int unsigned   PW      = DW + GW + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StRun  = 2'd2,
        StDown = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  gain_q, gain_d;
    logic [15:0]    pre_cnt_q, pre_cnt_d;
    logic           done_q, done_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic [DW-1:0]  dat_q, dat_d;

    logic           tick;
    logic           step_zero;
    logic [GW:0]    gain_up;
    logic signed [GW:0] gain_dn;
    logic           up_full;
    logic           dn_empty;

    // Tick and gain-step arithmetic, shared by the UP and DOWN branches.
    always_comb begin
        tick      = (pre_cnt_q == bus_if.set_rate_i);
        step_zero = (bus_if.set_step_i == '0);
        gain_up   = {1'b0, gain_q} + {1'b0, bus_if.set_step_i};
        gain_dn   = $signed({1'b0, gain_q}) - $signed({1'b0, bus_if.set_step_i});
        up_full   = (gain_up >= {1'b0, GainMax});
        dn_empty  = gain_dn[GW] || (gain_dn == '0);
    end

    // Ramp FSM next state; an en_i change always wins over a same-cycle tick.
    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        pre_cnt_d = pre_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                gain_d    = '0;
                pre_cnt_d = '0;
                if (bus_if.en_i) begin
                    if (step_zero) begin
                        state_d = StRun;
                        gain_d  = GainMax;
                    end else begin
                        state_d = StUp;
                    end
                end
            end
            StUp: begin
                if (!bus_if.en_i) begin
                    state_d   = StDown;
                    pre_cnt_d = '0;
                end else if (tick) begin
                    pre_cnt_d = '0;
                    if (up_full) begin
                        gain_d  = GainMax;
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        gain_d = gain_up[GW-1:0];
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + 16'd1;
                end
            end
            StRun: begin
                gain_d    = GainMax;
                pre_cnt_d = '0;
                if (!bus_if.en_i) begin
                    if (step_zero) begin
                        state_d = StIdle;
                        gain_d  = '0;
                    end else begin
                        state_d = StDown;
                    end
                end
            end
            StDown: begin
                if (bus_if.en_i) begin
                    state_d   = StUp;
                    pre_cnt_d = '0;
                end else if (tick) begin
                    pre_cnt_d = '0;
                    if (dn_empty) begin
                        gain_d  = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        gain_d = gain_dn[GW-1:0];
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                gain_d    = '0;
                pre_cnt_d = '0;
            end
        endcase
    end

    // Datapath: the gain on gain_o this cycle scales the sample on dat_i this cycle.
    always_comb begin
        prod_d = $signed(bus_if.dat_i) * $signed({1'b0, gain_q});
        dat_d  = prod_q[DW+GW-2:GW-1];
    end

    // All state and pipeline registers, synchronously reset.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q   <= StIdle;
            gain_q    <= '0;
            pre_cnt_q <= '0;
            done_q    <= 1'b0;
            prod_q    <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            pre_cnt_q <= pre_cnt_d;
            done_q    <= done_d;
            prod_q    <= prod_d;
            dat_q     <= dat_d;
        end
    end

    // Fraction bits and the redundant sign bit of the product are dropped by design.
    logic unused_prod;
    assign unused_prod = ^{prod_q[PW-1], prod_q[GW-2:0]};

    assign bus_if.dat_o   = dat_q;
    assign bus_if.gain_o  = gain_q;
    assign bus_if.state_o = state_q;
    assign bus_if.done_o  = done_q;

endmodule

// File: doc/rp_asg_ramp.md
# rp_asg_ramp

Soft-start/soft-stop gain stage placed directly downstream of an ASG channel's 14-bit `dac_o`, before the DAC interface. On output enable or disable it ramps a Q1.15 gain between 0 and 1.0 with programmable step and rate, so the analog output never jumps on switch-on or switch-off. At full gain it is a pure 2-cycle delay.

## Interface
Parameters:
- `DW`, 14: sample width, two's complement.
- `GW`, 16: gain register width; full scale is 0x8000 = 1.0.

Ports:
- `dac_clk_i` in 1: DAC clock; the only clock.
- `dac_rst_i` in 1: reset, synchronous, active-high.
- `dat_i` in DW: signed sample from the ASG channel, valid every clock.
- `en_i` in 1: output enable request (level).
- `set_step_i` in GW: gain increment/decrement per tick. 0 means no ramp (jump).
- `set_rate_i` in 16: clocks between ticks minus 1. 0 means a tick every clock.
- `dat_o` out DW: scaled sample.
- `gain_o` out GW: current gain.
- `state_o` out 2: 0 IDLE, 1 UP, 2 RUN, 3 DOWN.
- `done_o` out 1: one-cycle pulse on ramp completion.

## Operation
- `set_step_i` and `set_rate_i` are sampled live; they may change mid-ramp and take effect at the next tick.
- Prescaler `pre_cnt` (16 bit):
  - Cleared on every state change.
  - Otherwise increments each clock in UP/DOWN.
  - Tick = (`pre_cnt` == `set_rate_i`) in UP/DOWN; `pre_cnt` clears on tick.
- Gain arithmetic uses a 17-bit sum:
  - UP: `gain = min(gain + step, 0x8000)`.
  - DOWN: `gain = max(gain - step, 0)`, computed signed.
  - Gain never leaves [0, 0x8000].
- State transitions:
  - IDLE: gain = 0. If `en_i` = 1 → UP, or → RUN with gain = 0x8000 if `step` = 0.
  - UP: if `en_i` = 0 → DOWN, keeping the current gain, no tick that cycle. On a tick reaching 0x8000 → RUN, `done_o` = 1.
  - RUN: gain = 0x8000. If `en_i` = 0 → DOWN, or → IDLE with gain = 0 if `step` = 0.
  - DOWN: if `en_i` = 1 → UP, keeping the current gain. On a tick reaching 0 → IDLE, `done_o` = 1.
  - The `en_i` check takes priority over a tick in the same cycle.
- Datapath:
  - `prod = $signed(dat_i) * $signed({1'b0, gain})`, 31 bits, registered.
  - `dat_o = prod[DW+14:15]`, an arithmetic shift right by 15 (floor), registered.
  - No saturation is needed: |gain| ≤ 1.0, so −8192·1.0 = −8192 fits.
  - Gain 0x8000 reproduces `dat_i` exactly. Gain 0 gives 0.
- `done_o` does not pulse on the `step` = 0 jumps.

## Timing
- Reset values: state IDLE, gain 0, `pre_cnt` 0, `dat_o` 0, `gain_o` 0, `state_o` 0, `done_o` 0, product register 0.
- Reset takes effect at the next edge, including mid-ramp. The output is 0 two clocks later at the latest, since the pipeline registers are reset too.
- Latency `dat_i` → `dat_o`: 2 clocks. The gain applied to a sample is `gain_o` as it stands in the cycle that sample is on `dat_i`.
- Gain timing:
  - `gain_o` updates one clock after the tick condition.
  - `state_o` and `done_o` update on the same edge as the gain that causes them.
- Ramp duration: ceil(0x8000 / step) × (rate + 1) clocks from the entry into UP or DOWN.
- `en_i` toggling every clock: the state alternates UP↔DOWN, the gain holds, and no tick ever fires. This is accepted behaviour.

## Test plan
- Reset mid-ramp (gain 0x4000, UP), `dat_i` = 0x1000, `dac_rst_i` pulsed for 1 clock → next edge: state 0, gain 0; `dat_o` = 0 within 2 clocks; stays 0 with `en_i` = 0.
- Full ramp up: `step` = 0x2000, `rate` = 3, `dat_i` = 0x1FFF constant, `en_i` rises → gain steps 0x2000/0x4000/0x6000/0x8000 every 4 clocks. After 16 clocks state = RUN with `done_o` = 1 for 1 clock. `dat_o` = 0x07FF, 0x0FFF, 0x17FF, 0x1FFF, each 2 clocks after its gain.
- Negative floor and saturation: `dat_i` = −8192, gain 0x8000 → `dat_o` = −8192. Gain 0x0001 → `dat_o` = −1. Gain 0 → 0.
- Non-dividing step: `step` = 0x3000, `rate` = 0 → gain 0x3000, 0x6000, 0x8000 (clamped), then RUN. Ramp down gives 0x5000, 0x2000, 0x0000, then IDLE, with a `done_o` pulse each way.
- Reversal: `en_i` dropped when gain = 0x4000 in UP → DOWN from 0x4000, `pre_cnt` restarts, no `done_o`. `en_i` raised again at gain 0x2000 → UP resumes from 0x2000.
- Bypass: `step` = 0, `en_i` rises → RUN and gain 0x8000 on the next clock, `done_o` stays 0. `en_i` falls → IDLE and gain 0 on the next clock.
